sdio_cmd_phy: RTL

//  CMD-line front end for the SD-host-facing command path. Deserialises 48-bit host command

---
 rtl/sdio_cmd_phy_if.sv | 24 ++
 rtl/sdio_cmd_phy.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/sdio_cmd_phy_if.sv
// Command-path bundle between the CMD pin / command decoder and the SD CMD-line PHY.
// master = PHY side, slave = pad + decoder side.
interface sdio_cmd_phy_if;
    logic        cmd_in;
    logic        cmd_out;
    logic        cmd_oe;
    logic        req_valid;
    logic [5:0]  req_cmd;
    logic [31:0] req_arg;
    logic        resp_valid;
    logic [31:0] resp_arg;
    logic        crc_err;
    logic        resp_timeout;

    modport master (
        input  cmd_in, resp_valid, resp_arg,
        output cmd_out, cmd_oe, req_valid, req_cmd, req_arg, crc_err, resp_timeout
    );

    modport slave (
        output cmd_in, resp_valid, resp_arg,
        input  cmd_out, cmd_oe, req_valid, req_cmd, req_arg, crc_err, resp_timeout
    );
endinterface

// File: rtl/sdio_cmd_phy.sv
// SD CMD-line PHY: receives 48-bit host command frames, checks dir/CRC7/end bit, strobes them
// to the decoder, then serialises the decoder's response frame after an NCR gap.
module sdio_cmd_phy #(
    parameter int NCR          = 2,
    parameter int RESP_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    sdio_cmd_phy_if.master  bus
);

    localparam int CMAX = ((NCR > RESP_TIMEOUT) ? NCR : RESP_TIMEOUT) + 1;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] NCR_C = CW'(NCR);
    localparam logic [CW-1:0] RTO_C = CW'(RESP_TIMEOUT);

    typedef enum logic [2:0] {IDLE, RX, WAIT_RESP, GAP, TX} state_e;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
        return c;
    endfunction

    state_e        state_q;
    logic [5:0]    bcnt_q;
    logic [45:0]   rx_sr_q;
    logic [6:0]    rx_crc_q;
    logic [CW-1:0] cnt_q;
    logic [47:0]   tx_sr_q;
    logic [5:0]    tx_cnt_q;
    logic          cmd_out_q, cmd_oe_q;
    logic          req_valid_q, crc_err_q, resp_timeout_q;
    logic [5:0]    req_cmd_q;
    logic [31:0]   req_arg_q;

    logic [6:0]    rx_crc_d;
    logic [CW-1:0] cnt_d;
    logic [39:0]   resp_hdr_d;
    logic [47:0]   resp_frame_d;

    assign rx_crc_d     = crc7_step(rx_crc_q, bus.cmd_in);
    assign cnt_d        = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    // Response echoes the accepted command index with dir=0.
    assign resp_hdr_d   = {1'b0, 1'b0, req_cmd_q, bus.resp_arg};
    assign resp_frame_d = {resp_hdr_d, crc7_40(resp_hdr_d), 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            bcnt_q         <= '0;
            rx_sr_q        <= '0;
            rx_crc_q       <= '0;
            cnt_q          <= '0;
            tx_sr_q        <= '0;
            tx_cnt_q       <= '0;
            cmd_out_q      <= 1'b1;
            cmd_oe_q       <= 1'b0;
            req_valid_q    <= 1'b0;
            req_cmd_q      <= '0;
            req_arg_q      <= '0;
            crc_err_q      <= 1'b0;
            resp_timeout_q <= 1'b0;
        end else begin
            req_valid_q    <= 1'b0;
            crc_err_q      <= 1'b0;
            resp_timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!bus.cmd_in) begin
                        state_q  <= RX;
                        bcnt_q   <= 6'd46;
                        rx_crc_q <= '0;
                    end
                end
                RX: begin
                    // rx_sr_q holds bits 46..1 once the end bit arrives; the start bit is
                    // always 0 so it leaves a zero-init CRC unchanged and is not shifted in.
                    rx_sr_q <= {rx_sr_q[44:0], bus.cmd_in};
                    if (bcnt_q >= 6'd8) rx_crc_q <= rx_crc_d;
                    if (bcnt_q != 6'd0) begin
                        bcnt_q <= bcnt_q - 6'd1;
                    end else if (rx_sr_q[45] && (rx_sr_q[6:0] == rx_crc_q) && bus.cmd_in) begin
                        req_valid_q <= 1'b1;
                        req_cmd_q   <= rx_sr_q[44:39];
                        req_arg_q   <= rx_sr_q[38:7];
                        cnt_q       <= {{(CW-1){1'b0}}, 1'b1};
                        state_q     <= WAIT_RESP;
                    end else begin
                        crc_err_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                WAIT_RESP: begin
                    // cnt_q equals the number of edges since the end-bit edge.
                    cnt_q <= cnt_d;
                    if (bus.resp_valid) begin
                        tx_sr_q <= resp_frame_d;
                        state_q <= GAP;
                    end else if (cnt_q >= RTO_C) begin
                        resp_timeout_q <= 1'b1;
                        state_q        <= IDLE;
                    end
                end
                GAP: begin
                    if (cnt_q >= NCR_C) begin
                        cmd_oe_q  <= 1'b1;
                        cmd_out_q <= tx_sr_q[47];
                        tx_sr_q   <= {tx_sr_q[46:0], 1'b1};
                        tx_cnt_q  <= 6'd47;
                        state_q   <= TX;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                TX: begin
                    if (tx_cnt_q != 6'd0) begin
                        cmd_out_q <= tx_sr_q[47];
                        tx_sr_q   <= {tx_sr_q[46:0], 1'b1};
                        tx_cnt_q  <= tx_cnt_q - 6'd1;
                    end else begin
                        cmd_oe_q  <= 1'b0;
                        cmd_out_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_out      = cmd_out_q;
    assign bus.cmd_oe       = cmd_oe_q;
    assign bus.req_valid    = req_valid_q;
    assign bus.req_cmd      = req_cmd_q;
    assign bus.req_arg      = req_arg_q;
    assign bus.crc_err      = crc_err_q;
    assign bus.resp_timeout = resp_timeout_q;

endmodule
